mpeg_byte_fifo: RTL and testbench
=================================

// Module: mpeg_byte_fifo
// PURPOSE
//  Single-clock byte FIFO implementing the responder side of the MPEG byte-stream interface:
//  producers push with mpeg_wr and throttle on mpeg_prog_full; consumers pull with mpeg_rd and gate on mpeg_empty.
//  Read data appears one cycle after the pull. Sits at the scrambler core input and output stream boundaries.
//  Tracks end-of-stream so downstream logic knows when the last byte has drained.
// PARAMETERS
//  DEPTH            2048        entries, power of two; ADDR_W = $clog2(DEPTH)
//  PROG_FULL_THRESH DEPTH-16    occupancy at or above which mpeg_prog_full asserts; must be in 1..DEPTH
// PORTS
//  clk             in   1      clock
//  rst             in   1      synchronous, active-high reset
//  clk_en          in   1      global enable; low freezes all state
//  mpeg_in         in   8      write data
//  mpeg_wr         in   1      write strobe
//  stream_end      in   1      producer has written its final byte (level or pulse)
//  mpeg_rd         in   1      read strobe
//  mpeg_out        out  8      read data, valid the cycle after an accepted read
//  mpeg_ready      out  1      mpeg_out valid strobe
//  mpeg_empty      out  1      occupancy == 0
//  mpeg_full       out  1      occupancy == DEPTH
//  mpeg_prog_full  out  1      occupancy >= PROG_FULL_THRESH
//  stream_done     out  1      sticky: end seen and every byte read out
//  overflow        out  1      sticky: write attempted while full
//  underflow       out  1      sticky: read attempted while empty
// BEHAVIOUR
//  - Reset: pointers, occupancy, mpeg_out=8'h00, mpeg_ready, stream_done, overflow, underflow and end_seen are all cleared; mpeg_empty=1.
//  - All updates are qualified by clk_en. With clk_en=0, strobes are ignored and the outputs hold their values.
//  - Occupancy register cnt is ADDR_W+1 bits. The flags are decoded combinationally from cnt after the edge that updated it.
//  - Write accepted = mpeg_wr & ~mpeg_full: RAM[wptr]<=mpeg_in; wptr wraps modulo DEPTH.
//  - Write while full: data is dropped, overflow is set, and wptr/cnt are unchanged.
//  - Read accepted = mpeg_rd & ~mpeg_empty: mpeg_out<=RAM[rptr] and mpeg_ready<=1 at the next edge. Latency is 1.
//  - Read while empty: mpeg_ready<=0, underflow is set, and mpeg_out holds its value.
//  - Simultaneous accepted read and write: cnt is unchanged; both pointers advance.
//  - Write into an empty FIFO: the byte is readable no earlier than the following cycle; an mpeg_rd in the same cycle counts as a read while empty.
//  - Write and read in the same cycle while full: the write is dropped (full is evaluated before the read), the read is accepted, and cnt is decremented.
//  - end_seen is set on any cycle with stream_end=1 and is sticky.
//  - stream_done<=1 when end_seen & cnt==0 & ~mpeg_wr. It is sticky until rst.
//  - Reset mid-stream discards the contents; no partial read data is emitted after reset.
// CONFIGURATION
//  MPEG_FIFO_CNT_EN defined: adds outputs wr_cnt[31:0] and rd_cnt[31:0].
//   - They count accepted writes and reads, wrap at 2^32, and clear on rst.
//   - They freeze with clk_en.
//  MPEG_FIFO_CNT_EN undefined: these ports and registers do not exist; all other behaviour is identical.
// STRUCTURE
//  - Shared package mpeg_fifo_pkg holds MPEG_BYTE_W=8, the default DEPTH and the PROG_FULL_MARGIN=16 constant.
//  - Sub-module mpeg_fifo_ram provides simple dual-port RAM with synchronous write and registered read, DEPTH x 8.
//  - Pointer, count and flag logic stay in this module.
// TESTING
//  All scenarios use DEPTH=16 and PROG_FULL_THRESH=12.
//  1. Reset, then write 0x00..0x0B over 12 cycles -> mpeg_prog_full rises after the 12th write; mpeg_empty=0; mpeg_full=0.
//  2. Write 16 bytes, then a 17th (0xAA) -> mpeg_full=1 and overflow=1; reading 16 returns bytes 0..15 in order, with no 0xAA.
//  3. Hold mpeg_rd=~mpeg_empty continuously with random writes -> mpeg_ready follows each accepted read by exactly 1 cycle, and data order is preserved across pointer wrap.
//  4. Read with FIFO empty, including the same cycle as the first write -> underflow=1 and mpeg_ready stays 0; the byte is read on the next cycle.
//  5. Write 5 bytes, pulse stream_end, read 5 -> stream_done rises only after cnt reaches 0 and then stays 1.
//  6. clk_en=0 for 4 cycles with strobes active, then rst with 8 bytes queued -> state frozen during clk_en=0; after rst, mpeg_empty=1, all flags 0, and no mpeg_ready.
//  With MPEG_FIFO_CNT_EN defined, scenario 3 additionally checks rd_cnt == wr_cnt - cnt.

Source files
------------

// File: rtl/mpeg_fifo_pkg.sv
// Shared constants for the MPEG byte-stream FIFO and its storage array.
package mpeg_fifo_pkg;

    localparam int unsigned MPEG_BYTE_W        = 8;
    localparam int unsigned MPEG_DEFAULT_DEPTH = 2048;
    localparam int unsigned PROG_FULL_MARGIN   = 16;
    localparam int unsigned EVT_CNT_W          = 32;

endpackage

// File: rtl/mpeg_fifo_ram.sv
// Simple dual-port byte RAM: synchronous write, registered read with a clearable output register.
module mpeg_fifo_ram
    import mpeg_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = MPEG_DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [MPEG_BYTE_W-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [MPEG_BYTE_W-1:0] rd_data
);

    logic [MPEG_BYTE_W-1:0] mem [DEPTH];
    logic [MPEG_BYTE_W-1:0] rd_data_d;
    logic [MPEG_BYTE_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value on cycles without an accepted read.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/mpeg_byte_fifo.sv
// Single-clock byte FIFO, responder side of the MPEG byte-stream interface, with end-of-stream tracking.
// Optional accepted-transfer counters wr_cnt/rd_cnt are built when MPEG_FIFO_CNT_EN is defined.
module mpeg_byte_fifo
    import mpeg_fifo_pkg::*;
#(
    parameter int unsigned DEPTH            = MPEG_DEFAULT_DEPTH,
    parameter int unsigned PROG_FULL_THRESH = DEPTH - PROG_FULL_MARGIN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic [MPEG_BYTE_W-1:0] mpeg_in,
    input  logic                   mpeg_wr,
    input  logic                   stream_end,
    input  logic                   mpeg_rd,
    output logic [MPEG_BYTE_W-1:0] mpeg_out,
    output logic                   mpeg_ready,
    output logic                   mpeg_empty,
    output logic                   mpeg_full,
    output logic                   mpeg_prog_full,
    output logic                   stream_done,
    output logic                   overflow,
    output logic                   underflow
`ifdef MPEG_FIFO_CNT_EN
    ,
    output logic [EVT_CNT_W-1:0]   wr_cnt,
    output logic [EVT_CNT_W-1:0]   rd_cnt
`endif
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wptr_d, wptr_q;
    logic [ADDR_W-1:0] rptr_d, rptr_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              ready_d, ready_q;
    logic              done_d, done_q;
    logic              ovf_d, ovf_q;
    logic              udf_d, udf_q;
    logic              end_seen_d, end_seen_q;
    logic              wr_acc, rd_acc;

    // Flags come straight from the occupancy register; full is judged before any same-cycle read.
    assign mpeg_empty     = (cnt_q == '0);
    assign mpeg_full      = (cnt_q == CNT_W'(DEPTH));
    assign mpeg_prog_full = (cnt_q >= CNT_W'(PROG_FULL_THRESH));

    assign wr_acc = clk_en & mpeg_wr & ~mpeg_full;
    assign rd_acc = clk_en & mpeg_rd & ~mpeg_empty;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        end_seen_d = end_seen_q;
        if (clk_en) begin
            ready_d = rd_acc;
            if (wr_acc) begin
                wptr_d = wptr_q + ADDR_W'(1);
            end
            if (rd_acc) begin
                rptr_d = rptr_q + ADDR_W'(1);
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
            if (mpeg_wr && mpeg_full) begin
                ovf_d = 1'b1;
            end
            if (mpeg_rd && mpeg_empty) begin
                udf_d = 1'b1;
            end
            if (stream_end) begin
                end_seen_d = 1'b1;
            end
            // Done only once the end marker is seen and nothing is left or arriving.
            if (end_seen_q && mpeg_empty && !mpeg_wr) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            end_seen_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            end_seen_q <= end_seen_d;
        end
    end

    mpeg_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wptr_q),
        .wr_data (mpeg_in),
        .rd_en   (rd_acc),
        .rd_addr (rptr_q),
        .rd_data (mpeg_out)
    );

    assign mpeg_ready  = ready_q;
    assign stream_done = done_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

`ifdef MPEG_FIFO_CNT_EN
    logic [EVT_CNT_W-1:0] wr_cnt_d, wr_cnt_q;
    logic [EVT_CNT_W-1:0] rd_cnt_d, rd_cnt_q;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (wr_acc) begin
            wr_cnt_d = wr_cnt_q + EVT_CNT_W'(1);
        end
        if (rd_acc) begin
            rd_cnt_d = rd_cnt_q + EVT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_mpeg_byte_fifo.sv
// Self-checking bench for mpeg_byte_fifo: queue-based reference model plus directed scenarios.
module tb_mpeg_byte_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned THRESH = 12;

    logic       clk = 1'b0;
    logic       rst, clk_en, mpeg_wr, stream_end, mpeg_rd;
    logic [7:0] mpeg_in;
    logic [7:0] mpeg_out;
    logic       mpeg_ready, mpeg_empty, mpeg_full, mpeg_prog_full;
    logic       stream_done, overflow, underflow;
`ifdef MPEG_FIFO_CNT_EN
    logic [31:0] wr_cnt, rd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mpeg_byte_fifo #(
        .DEPTH            (DEPTH),
        .PROG_FULL_THRESH (THRESH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clk_en         (clk_en),
        .mpeg_in        (mpeg_in),
        .mpeg_wr        (mpeg_wr),
        .stream_end     (stream_end),
        .mpeg_rd        (mpeg_rd),
        .mpeg_out       (mpeg_out),
        .mpeg_ready     (mpeg_ready),
        .mpeg_empty     (mpeg_empty),
        .mpeg_full      (mpeg_full),
        .mpeg_prog_full (mpeg_prog_full),
        .stream_done    (stream_done),
        .overflow       (overflow),
        .underflow      (underflow)
`ifdef MPEG_FIFO_CNT_EN
        ,
        .wr_cnt         (wr_cnt),
        .rd_cnt         (rd_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte queue plus sticky status bits, updated at each active edge.
    logic [7:0]  q[$];
    logic [7:0]  m_out;
    logic        m_ready, m_over, m_under, m_end, m_done;
    logic        m_valid = 1'b0;
    logic [31:0] m_wr, m_rd;

    always @(posedge clk) begin : model
        int  sz;
        bit  wr_ok, rd_ok;
        if (rst) begin
            q.delete();
            m_out   = 8'h00;
            m_ready = 1'b0;
            m_over  = 1'b0;
            m_under = 1'b0;
            m_end   = 1'b0;
            m_done  = 1'b0;
            m_wr    = 32'd0;
            m_rd    = 32'd0;
            m_valid = 1'b1;
        end else if (clk_en) begin
            sz    = q.size();
            wr_ok = mpeg_wr && (sz < int'(DEPTH));
            rd_ok = mpeg_rd && (sz > 0);
            if (m_end && sz == 0 && !mpeg_wr) m_done = 1'b1;
            if (stream_end) m_end = 1'b1;
            if (rd_ok) begin
                m_out   = q.pop_front();
                m_ready = 1'b1;
                m_rd    = m_rd + 32'd1;
            end else begin
                m_ready = 1'b0;
                if (mpeg_rd) m_under = 1'b1;
            end
            if (wr_ok) begin
                q.push_back(mpeg_in);
                m_wr = m_wr + 32'd1;
            end else if (mpeg_wr) begin
                m_over = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("out",       32'(mpeg_out),       32'(m_out));
            chk("ready",     32'(mpeg_ready),     32'(m_ready));
            chk("empty",     32'(mpeg_empty),     32'(q.size() == 0));
            chk("full",      32'(mpeg_full),      32'(q.size() == int'(DEPTH)));
            chk("prog_full", 32'(mpeg_prog_full), 32'(q.size() >= int'(THRESH)));
            chk("done",      32'(stream_done),    32'(m_done));
            chk("overflow",  32'(overflow),       32'(m_over));
            chk("underflow", 32'(underflow),      32'(m_under));
`ifdef MPEG_FIFO_CNT_EN
            chk("wr_cnt",    wr_cnt,              m_wr);
            chk("rd_cnt",    rd_cnt,              m_rd);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clk_en     = 1'b1;
        mpeg_wr    = 1'b0;
        mpeg_rd    = 1'b0;
        stream_end = 1'b0;
        mpeg_in    = 8'h00;
    endtask

    task automatic do_rst();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        mpeg_wr = 1'b1;
        mpeg_in = b;
        tick();
        mpeg_wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_empty", 32'(mpeg_empty), 32'd1);
        chk("rst_out",   32'(mpeg_out),   32'h00);

        // 1: prog_full rises on the 12th write
        for (int i = 0; i < 12; i++) begin
            push(8'(i));
            if (i == 10) chk("s1_pf_before", 32'(mpeg_prog_full), 32'd0);
        end
        chk("s1_pf",    32'(mpeg_prog_full), 32'd1);
        chk("s1_empty", 32'(mpeg_empty),     32'd0);
        chk("s1_full",  32'(mpeg_full),      32'd0);

        // 2: fill, overflow with 0xAA, drain in order
        do_rst();
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'hAA);
        chk("s2_full", 32'(mpeg_full), 32'd1);
        chk("s2_ovf",  32'(overflow),  32'd1);
        mpeg_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("s2_ready", 32'(mpeg_ready), 32'd1);
            chk("s2_data",  32'(mpeg_out),   32'(i));
        end
        mpeg_rd = 1'b0;
        tick();
        chk("s2_empty",  32'(mpeg_empty), 32'd1);
        chk("s2_ready0", 32'(mpeg_ready), 32'd0);

        // 3: continuous reads against random writes, across pointer wrap
        do_rst();
        for (int i = 0; i < 120; i++) begin
            mpeg_wr = 1'($urandom_range(0, 1));
            mpeg_in = 8'($urandom);
            mpeg_rd = ~mpeg_empty;
            tick();
`ifdef MPEG_FIFO_CNT_EN
            chk("s3_cnt_rel", rd_cnt, wr_cnt - 32'(q.size()));
`endif
        end
        idle();
        tick();

        // 4: read while empty, including the cycle of the first write
        do_rst();
        mpeg_rd = 1'b1;
        tick();
        chk("s4_udf",    32'(underflow),  32'd1);
        chk("s4_ready0", 32'(mpeg_ready), 32'd0);
        mpeg_wr = 1'b1;
        mpeg_in = 8'h5C;
        tick();
        mpeg_wr = 1'b0;
        chk("s4_ready1", 32'(mpeg_ready), 32'd0);
        chk("s4_empty",  32'(mpeg_empty), 32'd0);
        tick();
        chk("s4_ready2", 32'(mpeg_ready), 32'd1);
        chk("s4_data",   32'(mpeg_out),   32'h5C);
        mpeg_rd = 1'b0;
        tick();

        // 5: end-of-stream then drain
        do_rst();
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        stream_end = 1'b1;
        tick();
        stream_end = 1'b0;
        mpeg_rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s5_done_early", 32'(stream_done), 32'd0);
        end
        mpeg_rd = 1'b0;
        tick();
        chk("s5_done", 32'(stream_done), 32'd1);
        push(8'h77);
        chk("s5_sticky1", 32'(stream_done), 32'd1);
        tick();
        chk("s5_sticky2", 32'(stream_done), 32'd1);

        // 6: clock enable freeze, then reset with bytes queued
        do_rst();
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        tick();
        clk_en     = 1'b0;
        mpeg_wr    = 1'b1;
        mpeg_rd    = 1'b1;
        stream_end = 1'b1;
        mpeg_in    = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s6_frz_empty", 32'(mpeg_empty), 32'd0);
            chk("s6_frz_ready", 32'(mpeg_ready), 32'd0);
            chk("s6_frz_udf",   32'(underflow),  32'd0);
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_empty", 32'(mpeg_empty),  32'd1);
        chk("s6_ready", 32'(mpeg_ready),  32'd0);
        chk("s6_done",  32'(stream_done), 32'd0);
        chk("s6_ovf",   32'(overflow),    32'd0);
        chk("s6_udf",   32'(underflow),   32'd0);
        chk("s6_out",   32'(mpeg_out),    32'h00);
        tick();
        chk("s6_ready_after", 32'(mpeg_ready), 32'd0);

        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
